raster_ntri: RTL and testbench
==============================

Name: raster_ntri

Overview:
- Parametrised successor of the two-triangle edge-function rasterizer.
- Evaluates NUM_TRI triangles per pixel using incremental edge functions and barycentric interpolation.
- Produces texel addresses for an external combinational texture ROM, and a registered 6-bit RGB pixel to the VGA top.
- Sits between the vertex-setup stage, which supplies per-frame/per-line coefficients, and the VGA output mux.

Parameters:
- NUM_TRI, 4, number of triangles evaluated per pixel (1..8); lower index has higher priority.
- EW, 20, signed edge-function width.
- BW, 22, signed barycentric width, Q2.(BW-2).
- TB, 7, texel address bits per axis; taken from bits [BW-3 -: TB] of interpolated u/v.
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines.
- H_TOTAL, 800, pixels per line including blanking.
- V_TOTAL, 525, lines per frame.
- PIX_DIV, 2, clocks per pixel (>=2).
- BG_RGB, 6'b010101, background colour.

Ports:
- clk  in  1  pixel-domain clock.
- reset_n  in  1  asynchronous active-low reset.
- x  in  10  VGA horizontal counter.
- y  in  10  VGA vertical counter.
- render_mode  in  2  0 mask, 1 uv, 2 flat, 3 black.
- cull_back  in  1  1 = back-facing hits treated as miss.
- e_init  in  NUM_TRI*3*EW  per-triangle edge values at x=0 of the current line.
- e_dx  in  NUM_TRI*3*EW  per-triangle edge increment per pixel.
- b_init  in  NUM_TRI*2*BW  per-triangle {iz,iy} barycentrics at x=0.
- b_dx  in  NUM_TRI*2*BW  per-triangle {iz_dx,iy_dx}.
- uv_mode  in  NUM_TRI*2  per-triangle uv mapping: 0 u=iz,v=iy+iz; 1 u=iy+iz,v=iy; 2 u=iy,v=iz; 3 u=iz,v=iy.
- tri_color  in  NUM_TRI*6  flat colour per triangle.
- texel  in  1  ROM bit at (u_addr,v_addr), same cycle.
- tex_rgb  in  6  palette colour for a set texel.
- u_addr  out  TB  texel u of selected triangle.
- v_addr  out  TB  texel v of selected triangle.
- hit  out  1  registered: current pixel covered.
- hit_idx  out  3  registered winning triangle index.
- back_face  out  1  registered back-face flag of winner.
- rgb  out  6  registered pixel colour.

Behaviour:
- Reset (async, reset_n=0) forces the following values:
  - all edge, bary and uv registers = 0.
  - hit=0, hit_idx=0, back_face=0, rgb=0.
  - phase = PIX_DIV-1.
- Active region (y<V_ACTIVE, x<H_ACTIVE): phase counter 0..PIX_DIV-1, wraps.
- Phase 0 (EVAL):
  - every triangle: b_iy+=iy_dx, b_iz+=iz_dx.
  - uv registers load from the post-increment sums per uv_mode, all BW-bit wrap arithmetic.
  - Classify: front = all three edges <0; back = all three >0.
  - Winner = lowest i with front, or with back when cull_back=0.
  - Register hit/hit_idx/back_face.
- Phases 1..PIX_DIV-2: hold all state.
- Phase PIX_DIV-1 (SHADE):
  - rgb computed from registered hit/hit_idx and the current texel/tex_rgb:
    - miss → BG_RGB.
    - mode 0 → texel ? tex_rgb : BG_RGB.
    - mode 1 → texel ? tex_rgb : 6'b111111.
    - mode 2 → tri_color[hit_idx], halved per 2-bit channel (>>1) when back_face.
    - mode 3 → 0.
  - Every triangle: e += e_dx (EW-bit wrap).
- Latency: rgb valid PIX_DIV-1 clocks after EVAL; rgb holds between SHADE phases.
- u_addr/v_addr are combinational muxes of the uv registers of hit_idx; they settle one clock after EVAL.
- Line reload: y<V_ACTIVE and x==H_TOTAL-1 → edges←e_init, bary←b_init, phase←0.
- Frame reload: y==V_TOTAL-1 and x==H_TOTAL-1 → same reload.
- Outside those conditions, in blanking: all registers hold, rgb holds last value.
- Reload has priority over stepping.
- Coefficient inputs are sampled only at reload and at step; mid-line changes take effect from the next step.
- Reset asserted mid-line: the pipeline restarts at the next reload; the first line after reset is valid only after a reload.

Optional Feature:
- Macro RASTER_EDGE_INCL_EN.
- Defined: edge tests are inclusive (front = all <=0, back = all >=0). A pixel with all edges ==0 is front.
- Undefined: strict tests as above; zero-edge pixels miss.

Test Plan:
- Reset: reset_n=0 mid-frame → rgb=0, hit=0 immediately, without a clock edge.
- Single tri, front: NUM_TRI=1, e_init={-5,-5,-5}, e_dx=0, render_mode=2, tri_color=6'b001100 → after reload, every active pixel rgb=6'b001100, hit=1.
- Back-face path:
  - e_init={5,5,5}, cull_back=0 → rgb=6'b000100 (halved), back_face=1.
  - cull_back=1 → rgb=BG_RGB.
- Priority and edge stepping:
  - tri0 e_init={-1,-1,-1}, e_dx={1,0,0}; tri1 all -100, colours A/B.
  - Pixel 0 → A; pixel 1 edge becomes 0 → B (strict build), A (RASTER_EDGE_INCL_EN build).
- UV/texture:
  - b_init iz=0, iy=0, iz_dx=2^(BW-2-TB), uv_mode=0.
  - u_addr increments by 1 per pixel starting at 1.
  - Mode 0 with texel tied 1 → rgb=tex_rgb; texel 0 → BG_RGB; mode 1 with texel 0 → 6'b111111.
- Reload timing: change e_init mid-line → no effect until x==799; frame reload occurs at y=524,x=799; blanking holds rgb.

Source files
------------

// File: rtl/raster_ntri_if.sv
// Bundles the rasterizer's coordinate, coefficient, texture and pixel signals.
// The master side drives the VGA counters and coefficients. The slave side is the rasterizer.
interface raster_ntri_if #(
    parameter int NUM_TRI = 4,
    parameter int EW      = 20,
    parameter int BW      = 22,
    parameter int TB      = 7
);
    logic [9:0]              x;
    logic [9:0]              y;
    logic [1:0]              render_mode;
    logic                    cull_back;
    logic [NUM_TRI*3*EW-1:0] e_init;
    logic [NUM_TRI*3*EW-1:0] e_dx;
    logic [NUM_TRI*2*BW-1:0] b_init;
    logic [NUM_TRI*2*BW-1:0] b_dx;
    logic [NUM_TRI*2-1:0]    uv_mode;
    logic [NUM_TRI*6-1:0]    tri_color;
    logic                    texel;
    logic [5:0]              tex_rgb;
    logic [TB-1:0]           u_addr;
    logic [TB-1:0]           v_addr;
    logic                    hit;
    logic [2:0]              hit_idx;
    logic                    back_face;
    logic [5:0]              rgb;

    modport master (
        output x, y, render_mode, cull_back, e_init, e_dx, b_init, b_dx,
               uv_mode, tri_color, texel, tex_rgb,
        input  u_addr, v_addr, hit, hit_idx, back_face, rgb
    );

    modport slave (
        input  x, y, render_mode, cull_back, e_init, e_dx, b_init, b_dx,
               uv_mode, tri_color, texel, tex_rgb,
        output u_addr, v_addr, hit, hit_idx, back_face, rgb
    );
endinterface

// File: rtl/raster_ntri.sv
// N-triangle rasterizer using incremental edge functions, barycentric texel addressing and a registered 6-bit RGB output.
// Optional macro RASTER_EDGE_INCL_EN makes the edge tests inclusive, so zero-edge pixels count as hits.
module raster_ntri #(
    parameter int         NUM_TRI  = 4,
    parameter int         EW       = 20,
    parameter int         BW       = 22,
    parameter int         TB       = 7,
    parameter int         H_ACTIVE = 640,
    parameter int         V_ACTIVE = 480,
    parameter int         H_TOTAL  = 800,
    parameter int         V_TOTAL  = 525,
    parameter int         PIX_DIV  = 2,
    parameter logic [5:0] BG_RGB   = 6'b010101
) (
    input logic          clk,
    input logic          reset_n,
    raster_ntri_if.slave bus
);
    localparam int            PW      = $clog2(PIX_DIV);
    localparam logic [PW-1:0] PH_LAST = PW'(PIX_DIV - 1);

    function automatic logic [TB-1:0] tex_bits(input logic [BW-1:0] val);
        tex_bits = val[BW-3 -: TB];
    endfunction

    logic [PW-1:0] phase_reg;
    logic          active, reload, do_eval, do_shade;
    logic          hit_reg, back_face_reg;
    logic [2:0]    hit_idx_reg;
    logic [5:0]    rgb_reg, rgb_next;
    logic          win_hit, win_back;
    logic [2:0]    win_idx;
    logic [NUM_TRI-1:0] front, back;
    logic [TB-1:0] u_tex [NUM_TRI];
    logic [TB-1:0] v_tex [NUM_TRI];
    logic [5:0]    col_tri [NUM_TRI];
    logic [TB-1:0] u_sel, v_sel;
    logic [5:0]    col_sel;

    assign active   = (bus.y < 10'(V_ACTIVE)) && (bus.x < 10'(H_ACTIVE));
    assign reload   = (bus.x == 10'(H_TOTAL - 1)) &&
                      ((bus.y < 10'(V_ACTIVE)) || (bus.y == 10'(V_TOTAL - 1)));
    assign do_eval  = active && !reload && (phase_reg == '0);
    assign do_shade = active && !reload && (phase_reg == PH_LAST);

    // Reset parks the phase on SHADE so a stray active pixel cannot evaluate stale edges first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            phase_reg <= PH_LAST;
        else if (reload)
            phase_reg <= '0;
        else if (active)
            phase_reg <= (phase_reg == PH_LAST) ? '0 : phase_reg + PW'(1);
    end

    for (genvar gi = 0; gi < NUM_TRI; gi++) begin : g_tri
        logic [EW-1:0] e_reg [3];
        logic [BW-1:0] iy_reg, iz_reg, iy_next, iz_next, s_next;
        logic [TB-1:0] u_reg, v_reg;
        logic [2:0]    neg, zero;

        assign iy_next = iy_reg + bus.b_dx[gi*2*BW +: BW];
        assign iz_next = iz_reg + bus.b_dx[gi*2*BW + BW +: BW];
        assign s_next  = iy_next + iz_next;

        for (genvar gk = 0; gk < 3; gk++) begin : g_edge
            assign neg[gk]  = e_reg[gk][EW-1];
            assign zero[gk] = (e_reg[gk] == '0);
        end

`ifdef RASTER_EDGE_INCL_EN
        assign front[gi] = &(neg | zero);
        assign back[gi]  = &(~neg);
`else
        assign front[gi] = &neg;
        assign back[gi]  = &(~neg & ~zero);
`endif

        assign u_tex[gi]   = u_reg;
        assign v_tex[gi]   = v_reg;
        assign col_tri[gi] = bus.tri_color[gi*6 +: 6];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int k = 0; k < 3; k++) e_reg[k] <= '0;
                iy_reg <= '0;
                iz_reg <= '0;
                u_reg  <= '0;
                v_reg  <= '0;
            end else if (reload) begin
                for (int k = 0; k < 3; k++) e_reg[k] <= bus.e_init[(gi*3 + k)*EW +: EW];
                iy_reg <= bus.b_init[gi*2*BW +: BW];
                iz_reg <= bus.b_init[gi*2*BW + BW +: BW];
            end else if (do_eval) begin
                iy_reg <= iy_next;
                iz_reg <= iz_next;
                case (bus.uv_mode[gi*2 +: 2])
                    2'd0:    begin u_reg <= tex_bits(iz_next); v_reg <= tex_bits(s_next);  end
                    2'd1:    begin u_reg <= tex_bits(s_next);  v_reg <= tex_bits(iy_next); end
                    2'd2:    begin u_reg <= tex_bits(iy_next); v_reg <= tex_bits(iz_next); end
                    default: begin u_reg <= tex_bits(iz_next); v_reg <= tex_bits(iy_next); end
                endcase
            end else if (do_shade) begin
                for (int k = 0; k < 3; k++) e_reg[k] <= e_reg[k] + bus.e_dx[(gi*3 + k)*EW +: EW];
            end
        end
    end

    // Descending scan so the lowest-index covering triangle is the last one written.
    always_comb begin
        win_hit  = 1'b0;
        win_idx  = '0;
        win_back = 1'b0;
        for (int i = NUM_TRI - 1; i >= 0; i--) begin
            if (front[i] || (back[i] && !bus.cull_back)) begin
                win_hit  = 1'b1;
                win_idx  = 3'(i);
                win_back = !front[i];
            end
        end
    end

    always_comb begin
        u_sel   = '0;
        v_sel   = '0;
        col_sel = '0;
        for (int i = 0; i < NUM_TRI; i++) begin
            if (hit_idx_reg == 3'(i)) begin
                u_sel   = u_tex[i];
                v_sel   = v_tex[i];
                col_sel = col_tri[i];
            end
        end
    end

    always_comb begin
        rgb_next = BG_RGB;
        if (hit_reg) begin
            case (bus.render_mode)
                2'd0:    rgb_next = bus.texel ? bus.tex_rgb : BG_RGB;
                2'd1:    rgb_next = bus.texel ? bus.tex_rgb : 6'b111111;
                2'd2:    rgb_next = back_face_reg ?
                                    {1'b0, col_sel[5], 1'b0, col_sel[3], 1'b0, col_sel[1]} : col_sel;
                default: rgb_next = 6'b000000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_reg       <= 1'b0;
            hit_idx_reg   <= '0;
            back_face_reg <= 1'b0;
            rgb_reg       <= '0;
        end else if (do_eval) begin
            hit_reg       <= win_hit;
            hit_idx_reg   <= win_idx;
            back_face_reg <= win_back;
        end else if (do_shade) begin
            rgb_reg <= rgb_next;
        end
    end

    assign bus.u_addr    = u_sel;
    assign bus.v_addr    = v_sel;
    assign bus.hit       = hit_reg;
    assign bus.hit_idx   = hit_idx_reg;
    assign bus.back_face = back_face_reg;
    assign bus.rgb       = rgb_reg;
endmodule

// File: tb/tb_raster_ntri.sv
// Directed bench for raster_ntri: two triangles, VGA positions driven one pixel (PIX_DIV clocks) at a time.
module tb_raster_ntri;
    localparam int         NT      = 2;
    localparam int         EW      = 20;
    localparam int         BW      = 22;
    localparam int         TB      = 7;
    localparam int         PIX_DIV = 2;
    localparam logic [5:0] BG      = 6'b010101;
    localparam logic [5:0] COL_F   = 6'b001100;
    localparam logic [5:0] COL_H   = 6'b000100;
    localparam logic [5:0] COL_A   = 6'b110000;
    localparam logic [5:0] COL_B   = 6'b000011;
    localparam logic [5:0] TEX     = 6'b101010;
`ifdef RASTER_EDGE_INCL_EN
    localparam logic [5:0] EXP_P1  = COL_A;
    localparam int         EXP_I1  = 0;
`else
    localparam logic [5:0] EXP_P1  = COL_B;
    localparam int         EXP_I1  = 1;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   checks;
    int   failures;

    always #5 clk = ~clk;

    raster_ntri_if #(.NUM_TRI(NT), .EW(EW), .BW(BW), .TB(TB)) bus ();

    raster_ntri #(.NUM_TRI(NT), .EW(EW), .BW(BW), .TB(TB), .PIX_DIV(PIX_DIV), .BG_RGB(BG)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_tri(input int t, input int e0, input int e1, input int e2,
                           input int d0, input logic [5:0] col);
        bus.e_init[(t*3 + 0)*EW +: EW] = EW'(e0);
        bus.e_init[(t*3 + 1)*EW +: EW] = EW'(e1);
        bus.e_init[(t*3 + 2)*EW +: EW] = EW'(e2);
        bus.e_dx[(t*3 + 0)*EW +: EW]   = EW'(d0);
        bus.e_dx[(t*3 + 1)*EW +: EW]   = '0;
        bus.e_dx[(t*3 + 2)*EW +: EW]   = '0;
        bus.tri_color[t*6 +: 6]        = col;
    endtask

    // One pixel: hold x/y for PIX_DIV clocks (EVAL then SHADE), return 1 time unit past the last edge.
    task automatic pix(input int px, input int py);
        bus.x = 10'(px);
        bus.y = 10'(py);
        repeat (PIX_DIV) @(posedge clk);
        #1;
        $display("pix x=%0d y=%0d hit=%0b idx=%0d bf=%0b rgb=%06b u=%0d v=%0d",
                 px, py, bus.hit, bus.hit_idx, bus.back_face, bus.rgb, bus.u_addr, bus.v_addr);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset_n = 1'b1;
        bus.x = 10'd799;
        bus.y = 10'd524;
        bus.render_mode = 2'd2;
        bus.cull_back = 1'b0;
        bus.e_init = '0;
        bus.e_dx = '0;
        bus.b_init = '0;
        bus.b_dx = '0;
        bus.uv_mode = '0;
        bus.tri_color = '0;
        bus.texel = 1'b0;
        bus.tex_rgb = '0;
        set_tri(0, -5, -5, -5, 0, COL_F);
        set_tri(1, 100, -100, -100, 0, COL_B);

        // Asynchronous reset before any clock edge
        #1 reset_n = 1'b0;
        #1;
        check_eq("rst_rgb", 32'(bus.rgb), 32'd0);
        check_eq("rst_hit", 32'(bus.hit), 32'd0);
        check_eq("rst_idx", 32'(bus.hit_idx), 32'd0);
        check_eq("rst_bf", 32'(bus.back_face), 32'd0);
        check_eq("rst_u", 32'(bus.u_addr), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Single front-facing triangle, flat mode
        pix(799, 524);
        pix(0, 0);
        check_eq("front_rgb", 32'(bus.rgb), 32'(COL_F));
        check_eq("front_hit", 32'(bus.hit), 32'd1);
        check_eq("front_bf", 32'(bus.back_face), 32'd0);
        pix(1, 0);
        pix(2, 0);
        check_eq("front_rgb2", 32'(bus.rgb), 32'(COL_F));

        // Back-facing: halved colour, then culled
        set_tri(0, 5, 5, 5, 0, COL_F);
        pix(799, 0);
        pix(0, 1);
        check_eq("back_rgb", 32'(bus.rgb), 32'(COL_H));
        check_eq("back_bf", 32'(bus.back_face), 32'd1);
        check_eq("back_hit", 32'(bus.hit), 32'd1);
        bus.cull_back = 1'b1;
        pix(1, 1);
        check_eq("cull_rgb", 32'(bus.rgb), 32'(BG));
        check_eq("cull_hit", 32'(bus.hit), 32'd0);

        // Priority with edge stepping
        bus.cull_back = 1'b0;
        set_tri(0, -1, -1, -1, 1, COL_A);
        set_tri(1, -100, -100, -100, 0, COL_B);
        pix(799, 1);
        pix(0, 2);
        check_eq("prio0_rgb", 32'(bus.rgb), 32'(COL_A));
        check_eq("prio0_idx", 32'(bus.hit_idx), 32'd0);
        pix(1, 2);
        check_eq("prio1_rgb", 32'(bus.rgb), 32'(EXP_P1));
        check_eq("prio1_idx", 32'(bus.hit_idx), 32'(EXP_I1));
        pix(2, 2);
        check_eq("prio2_rgb", 32'(bus.rgb), 32'(COL_B));
        check_eq("prio2_idx", 32'(bus.hit_idx), 32'd1);

        // UV addressing and texture modes: iz steps one texel per pixel
        set_tri(0, -5, -5, -5, 0, COL_F);
        set_tri(1, 100, -100, -100, 0, COL_B);
        bus.b_dx[BW +: BW] = BW'(1 << (BW - 2 - TB));
        bus.render_mode = 2'd0;
        bus.texel = 1'b1;
        bus.tex_rgb = TEX;
        pix(799, 2);
        pix(0, 3);
        check_eq("uv0_u", 32'(bus.u_addr), 32'd1);
        check_eq("uv0_v", 32'(bus.v_addr), 32'd1);
        check_eq("tex_rgb", 32'(bus.rgb), 32'(TEX));
        pix(1, 3);
        check_eq("uv1_u", 32'(bus.u_addr), 32'd2);
        bus.texel = 1'b0;
        pix(2, 3);
        check_eq("tex0_rgb", 32'(bus.rgb), 32'(BG));
        check_eq("uv2_u", 32'(bus.u_addr), 32'd3);
        bus.render_mode = 2'd1;
        pix(3, 3);
        check_eq("uvmode_white", 32'(bus.rgb), 32'h3f);
        bus.uv_mode[1:0] = 2'd2;
        pix(4, 3);
        check_eq("uvm2_u", 32'(bus.u_addr), 32'd0);
        check_eq("uvm2_v", 32'(bus.v_addr), 32'd5);
        bus.render_mode = 2'd3;
        pix(5, 3);
        check_eq("black_rgb", 32'(bus.rgb), 32'd0);

        // Reload timing and blanking hold
        bus.render_mode = 2'd2;
        pix(6, 3);
        check_eq("pre_chg_rgb", 32'(bus.rgb), 32'(COL_F));
        set_tri(0, 5, 5, 5, 0, COL_F);
        pix(7, 3);
        check_eq("midline_rgb", 32'(bus.rgb), 32'(COL_F));
        check_eq("midline_bf", 32'(bus.back_face), 32'd0);
        pix(700, 3);
        check_eq("hblank_rgb", 32'(bus.rgb), 32'(COL_F));
        pix(799, 3);
        pix(0, 4);
        check_eq("reload_rgb", 32'(bus.rgb), 32'(COL_H));
        check_eq("reload_bf", 32'(bus.back_face), 32'd1);
        set_tri(0, -5, -5, -5, 0, COL_F);
        pix(799, 480);
        pix(0, 481);
        check_eq("vblank_rgb", 32'(bus.rgb), 32'(COL_H));
        check_eq("vblank_bf", 32'(bus.back_face), 32'd1);
        pix(799, 524);
        pix(0, 0);
        check_eq("frame_rgb", 32'(bus.rgb), 32'(COL_F));
        check_eq("frame_bf", 32'(bus.back_face), 32'd0);

        // Mid-line asynchronous reset between clock edges
        pix(1, 0);
        #2 reset_n = 1'b0;
        #1;
        check_eq("midrst_rgb", 32'(bus.rgb), 32'd0);
        check_eq("midrst_hit", 32'(bus.hit), 32'd0);
        #3 reset_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
